// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_branch_unit
// Purpose  : Holds the architectural PC and resolves B / BR / PCS / HLT using
//            the registered ALU condition flags {V,N,Z}. Drives the fetch
//            redirect (pc), a one-cycle flush after each accepted taken
//            branch, the halt indication and a saturating taken-branch count.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous active-low reset (0 = reset)
//            stall     - 1 = hold pc/state/count this cycle, flush clears
//            opcode    - current instruction opcode
//            ccc       - branch condition field
//            imm9      - signed B offset in words
//            rs_data   - register target for BR (used unaligned, as-is)
//            flags     - [2]=V [1]=N [0]=Z
//            pc        - current PC (registered)
//            pc_plus2  - pc+2 (combinational, PCS write-back data)
//            taken     - current B/BR condition true (combinational)
//            flush     - 1 for one cycle after an accepted taken branch
//            halted    - 1 while in HALT
//            taken_cnt - saturating count of accepted taken branches
// Revision : 1.0 - initial release
// ============================================================================
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [3:0]       opcode,
  input  logic [2:0]       ccc,
  input  logic [8:0]       imm9,
  input  logic [15:0]      rs_data,
  input  logic [2:0]       flags,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus2,
  output logic             taken,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [3:0]       OP_B    = 4'hC;
  localparam logic [3:0]       OP_BR   = 4'hD;
  localparam logic [3:0]       OP_HLT  = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        flag_v, flag_n, flag_z;
  logic        cond;
  logic        run;
  logic        is_branch;
  logic        accept;
  logic [15:0] b_offset;
  logic [15:0] next_pc;

  assign {flag_v, flag_n, flag_z} = flags;

  always_comb begin
    cond = 1'b0;
    case (ccc)
      3'b000:  cond = ~flag_z;             // NEQ
      3'b001:  cond = flag_z;              // EQ
      3'b010:  cond = ~flag_z & ~flag_n;   // GT
      3'b011:  cond = flag_n;              // LT
      3'b100:  cond = flag_z | ~flag_n;    // GTE
      3'b101:  cond = flag_n | flag_z;     // LTE
      3'b110:  cond = flag_v;              // OVFL
      default: cond = 1'b1;                // UNCOND
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
  // Gated by run so a halted core never reports a taken branch.
  assign taken     = run & is_branch & cond;
  assign pc_plus2  = pc_q + 16'd2;
  // Word offset: sign-extend imm9 and shift left by one into a byte offset.
  assign b_offset  = {{6{imm9[8]}}, imm9, 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (taken && (opcode == OP_B)) begin
      next_pc = pc_plus2 + b_offset;
    end else if (taken && (opcode == OP_BR)) begin
      next_pc = rs_data;
    end else if (opcode == OP_HLT) begin
      next_pc = pc_q;
    end
  end

  assign accept = run & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    if (accept) begin
      pc_d    = next_pc;
      flush_d = taken;
      if (taken && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (opcode == OP_HLT) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign halted    = (state_q == ST_HALT);
  assign taken_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_branch_unit
// Purpose  : Self-checking bench for pc_branch_unit. A 16-bit-counter instance
//            and a 4-bit-counter instance share all inputs; a behavioural
//            model predicts pc, flush, halted, taken and the counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  logic        clk, rst, stall;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] rs_data;
  logic [2:0]  flags;

  logic [15:0] pc, pc_plus2, pc_s, pp2_s;
  logic        taken, flush, halted, taken_s, flush_s, halted_s;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  pc_branch_unit #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .ccc(ccc),
    .imm9(imm9), .rs_data(rs_data), .flags(flags), .pc(pc),
    .pc_plus2(pc_plus2), .taken(taken), .flush(flush), .halted(halted),
    .taken_cnt(cnt16)
  );

  pc_branch_unit #(.RESET_PC(16'h0000), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .ccc(ccc),
    .imm9(imm9), .rs_data(rs_data), .flags(flags), .pc(pc_s),
    .pc_plus2(pp2_s), .taken(taken_s), .flush(flush_s), .halted(halted_s),
    .taken_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // Behavioural model state
  logic [15:0] m_pc;
  bit          m_halted, m_flush, exp_taken;
  int          m_cnt;
  logic        obs_taken;
  logic [15:0] obs_pp2, exp_pp2;

  function automatic bit mcond(input logic [2:0] c, input logic [2:0] f);
    bit v, n, z;
    v = f[2]; n = f[1]; z = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_halted = 0; m_flush = 0; m_cnt = 0;
  endtask

  // Drive one instruction, sample combinational outputs mid-cycle, advance one
  // edge and update the model. Called at posedge+1; returns at posedge+1.
  task automatic step(input logic [3:0] op, input logic [2:0] c, input logic [8:0] im,
                      input logic [15:0] rs, input logic [2:0] fl, input bit st);
    opcode = op; ccc = c; imm9 = im; rs_data = rs; flags = fl; stall = st;
    exp_taken = !m_halted && mcond(c, fl) && (op == 4'hC || op == 4'hD);
    exp_pp2   = m_pc + 16'd2;
    #2;
    obs_taken = taken;
    obs_pp2   = pc_plus2;
    @(posedge clk); #1;
    if (!m_halted && !st) begin
      m_flush = exp_taken;
      if (exp_taken) m_cnt++;
      if (op == 4'hC && exp_taken)
        m_pc = 16'(int'(m_pc) + 2 + 2 * int'($signed(im)));
      else if (op == 4'hD && exp_taken)
        m_pc = rs;
      else if (op == 4'hF)
        m_halted = 1;
      else
        m_pc = m_pc + 16'd2;
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic set_pc(input logic [15:0] target);
    step(4'hD, 3'b111, 9'h000, target, 3'b000, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; opcode = 4'h0; ccc = 3'b000; imm9 = '0;
    rs_data = '0; flags = '0;
    model_reset();
    #1;
    tot++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pc); end
    tot++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
    tot++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    tot++; if (cnt16 !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h want=0000", cnt16); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
      tot++; if (pc !== 16'(2 * i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, pc, 16'(2 * i)); end
      tot++; if (flush !== 1'b0 || cnt16 !== 16'h0) begin bad++; $display("FAIL seq_flush_cnt[%0d] got=%b/%h want=0/0", i, flush, cnt16); end
    end
  endtask

  task automatic test_branch_b();
    set_pc(16'h0010);
    step(4'hC, 3'b001, 9'h004, 16'h0000, 3'b001, 0);
    tot++; if (pc !== 16'h001A) begin bad++; $display("FAIL b_taken_pc got=%h want=001a", pc); end
    tot++; if (flush !== 1'b1) begin bad++; $display("FAIL b_taken_flush got=%b want=1", flush); end
    tot++; if (cnt16 !== 16'(m_cnt)) begin bad++; $display("FAIL b_taken_cnt got=%0d want=%0d", cnt16, m_cnt); end
    step(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
    tot++; if (flush !== 1'b0) begin bad++; $display("FAIL b_flush_clear got=%b want=0", flush); end
    set_pc(16'h0010);
    step(4'hC, 3'b001, 9'h004, 16'h0000, 3'b000, 0);
    tot++; if (pc !== 16'h0012) begin bad++; $display("FAIL b_nt_pc got=%h want=0012", pc); end
    tot++; if (flush !== 1'b0) begin bad++; $display("FAIL b_nt_flush got=%b want=0", flush); end
  endtask

  task automatic test_cond_sweep();
    set_pc(16'h0100);
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        step(4'hC, 3'(c), 9'h1FF, 16'h0000, 3'(f), 0);
        tot++; if (obs_taken !== exp_taken) begin bad++; $display("FAIL sweep_taken ccc=%0d flags=%0d got=%b want=%b", c, f, obs_taken, exp_taken); end
        tot++; if (pc !== m_pc || flush !== m_flush) begin bad++; $display("FAIL sweep_pc ccc=%0d flags=%0d got=%h/%b want=%h/%b", c, f, pc, flush, m_pc, m_flush); end
        if (c == 4 && f == 2) begin
          tot++; if (obs_taken !== 1'b0) begin bad++; $display("FAIL sweep_gte_n got=%b want=0", obs_taken); end
        end
      end
    end
  endtask

  task automatic test_br_stall();
    set_pc(16'h0040);
    step(4'hD, 3'b111, 9'h000, 16'h1234, 3'b000, 1);
    tot++; if (pc !== 16'h0040 || flush !== 1'b0) begin bad++; $display("FAIL br_stall got=%h/%b want=0040/0", pc, flush); end
    step(4'hD, 3'b111, 9'h000, 16'h1234, 3'b000, 0);
    tot++; if (pc !== 16'h1234 || flush !== 1'b1) begin bad++; $display("FAIL br_taken got=%h/%b want=1234/1", pc, flush); end
    step(4'hE, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
    tot++; if (obs_pp2 !== 16'h1236 || pc !== 16'h1236) begin bad++; $display("FAIL pcs got=%h/%h want=1236/1236", obs_pp2, pc); end
  endtask

  task automatic test_back_to_back();
    step(4'hC, 3'b111, 9'h010, 16'h0000, 3'b000, 0);
    step(4'hC, 3'b111, 9'h010, 16'h0000, 3'b000, 0);
    tot++; if (flush !== 1'b1 || pc !== m_pc) begin bad++; $display("FAIL b2b got=%h/%b want=%h/1", pc, flush, m_pc); end
    step(4'hD, 3'b111, 9'h000, 16'h0777, 3'b000, 0);
    tot++; if (flush !== 1'b1 || pc !== 16'h0777) begin bad++; $display("FAIL b2b_br got=%h/%b want=0777/1", pc, flush); end
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFE);
    step(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
    tot++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_fwd got=%h want=0000", pc); end
    step(4'hC, 3'b111, 9'h1FE, 16'h0000, 3'b000, 0);
    tot++; if (pc !== 16'hFFFE) begin bad++; $display("FAIL wrap_back got=%h want=fffe", pc); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom_range(0, 14));
      step(op, 3'($urandom), 9'($urandom), 16'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
      tot++;
      if (pc !== m_pc || flush !== m_flush || halted !== m_halted || obs_taken !== exp_taken ||
          obs_pp2 !== exp_pp2 || cnt16 !== 16'(sat(m_cnt, 16)) || cnt4 !== 4'(sat(m_cnt, 4))) begin
        bad++;
        $display("FAIL rand[%0d] got pc=%h fl=%b h=%b tk=%b pp2=%h c16=%0d c4=%0d want pc=%h fl=%b h=%b tk=%b pp2=%h c16=%0d c4=%0d",
                 i, pc, flush, halted, obs_taken, obs_pp2, cnt16, cnt4,
                 m_pc, m_flush, m_halted, exp_taken, exp_pp2, sat(m_cnt, 16), sat(m_cnt, 4));
      end
    end
  endtask

  task automatic test_halt();
    // Reset while flush is high
    step(4'hC, 3'b111, 9'h003, 16'h0000, 3'b000, 0);
    #1 rst = 1'b0;
    #1;
    tot++; if (pc !== 16'h0000 || flush !== 1'b0 || cnt16 !== 16'h0) begin bad++; $display("FAIL rst_flush got=%h/%b/%h want=0000/0/0", pc, flush, cnt16); end
    #1 rst = 1'b1;
    model_reset();
    set_pc(16'h0008);
    step(4'hF, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
    tot++; if (pc !== 16'h0008 || halted !== 1'b1) begin bad++; $display("FAIL hlt got=%h/%b want=0008/1", pc, halted); end
    for (int i = 0; i < 10; i++) begin
      step(4'hC, 3'b111, 9'($urandom), 16'h0000, 3'($urandom), 0);
      tot++;
      if (pc !== 16'h0008 || halted !== 1'b1 || flush !== 1'b0 || obs_taken !== 1'b0 || cnt16 !== 16'(m_cnt)) begin
        bad++;
        $display("FAIL halt_hold[%0d] got=%h/%b/%b/%b/%0d want=0008/1/0/0/%0d", i, pc, halted, flush, obs_taken, cnt16, m_cnt);
      end
    end
    #1 rst = 1'b0;
    #1;
    tot++; if (pc !== 16'h0000 || halted !== 1'b0) begin bad++; $display("FAIL rst_halt got=%h/%b want=0000/0", pc, halted); end
    #1 rst = 1'b1;
    model_reset();
    step(4'h0, 3'b000, 9'h000, 16'h0000, 3'b000, 0);
    tot++; if (pc !== 16'h0002 || halted !== 1'b0) begin bad++; $display("FAIL after_rst got=%h/%b want=0002/0", pc, halted); end
  endtask

  task automatic test_sat();
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 17; i++) begin
      step(4'hC, 3'b111, 9'h000, 16'h0000, 3'b000, 0);
      if (i == 14) begin
        tot++; if (cnt4 !== 4'hF) begin bad++; $display("FAIL sat15 got=%h want=f", cnt4); end
      end
    end
    tot++; if (cnt4 !== 4'hF) begin bad++; $display("FAIL sat17 got=%h want=f", cnt4); end
    tot++; if (cnt16 !== 16'd17) begin bad++; $display("FAIL cnt17 got=%0d want=17", cnt16); end
  endtask

  initial begin
    test_reset();
    test_branch_b();
    test_cond_sweep();
    test_br_stall();
    test_back_to_back();
    test_wrap();
    test_random();
    test_halt();
    test_sat();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
